// File: rtl/divider_sweep_controller.sv
// Power-of-two divider sweep: square wave on signal, stepping MIN_DIV..MAX_DIV every 2^DWELL_LOG2 cycles.
// All outputs registered (one-cycle latency from start/stop/hold); hold freezes dwell, stop returns to IDLE.
module divider_sweep_controller #(
  parameter int MIN_DIV    = 1,
  parameter int MAX_DIV    = 21,
  parameter int DWELL_LOG2 = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       hold,
  input  logic       loop,
  output logic       signal,
  output logic [4:0] cur_div,
  output logic       busy,
  output logic       step_strobe
);

  typedef enum logic [1:0] {IDLE, SWEEP, PAUSE} state_t;

  localparam logic [4:0] MIN_D = 5'(MIN_DIV);
  localparam logic [4:0] MAX_D = 5'(MAX_DIV);

  state_t                state, state_nxt;
  logic [30:0]           hc, hc_nxt;
  logic [30:0]           half_max;
  logic [DWELL_LOG2-1:0] dwell, dwell_nxt;
  logic                  signal_nxt, busy_nxt, step_strobe_nxt;
  logic [4:0]            cur_div_nxt;

  param_legal: assert property (@(posedge clk)
    (MIN_DIV >= 1) && (MIN_DIV <= MAX_DIV) && (MAX_DIV <= 31) && (DWELL_LOG2 >= MAX_DIV));

  // Half period of 2^cur_div is 2^(cur_div-1) cycles; cur_div is never below 1.
  assign half_max = (31'd1 << (cur_div - 5'd1)) - 31'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hc          <= '0;
      dwell       <= '0;
      signal      <= 1'b0;
      cur_div     <= MIN_D;
      busy        <= 1'b0;
      step_strobe <= 1'b0;
    end else begin
      state       <= state_nxt;
      hc          <= hc_nxt;
      dwell       <= dwell_nxt;
      signal      <= signal_nxt;
      cur_div     <= cur_div_nxt;
      busy        <= busy_nxt;
      step_strobe <= step_strobe_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    hc_nxt          = hc;
    dwell_nxt       = dwell;
    signal_nxt      = signal;
    cur_div_nxt     = cur_div;
    busy_nxt        = busy;
    step_strobe_nxt = 1'b0;
    case (state)
      IDLE: begin
        hc_nxt      = '0;
        dwell_nxt   = '0;
        signal_nxt  = 1'b0;
        cur_div_nxt = MIN_D;
        busy_nxt    = 1'b0;
        if (start && !stop) begin
          state_nxt = SWEEP;
          busy_nxt  = 1'b1;
        end
      end
      SWEEP, PAUSE: begin
        busy_nxt  = 1'b1;
        state_nxt = hold ? PAUSE : SWEEP;
        if (hc == half_max) begin
          hc_nxt     = '0;
          signal_nxt = ~signal;
        end else begin
          hc_nxt = hc + 31'd1;
        end
        if (state == SWEEP) dwell_nxt = dwell + DWELL_LOG2'(1);
        // Step event: restart phase at the new divisor so the first half period is clean.
        if (state == SWEEP && (&dwell)) begin
          if (cur_div < MAX_D || loop) begin
            cur_div_nxt     = (cur_div < MAX_D) ? cur_div + 5'd1 : MIN_D;
            hc_nxt          = '0;
            signal_nxt      = 1'b0;
            dwell_nxt       = '0;
            step_strobe_nxt = 1'b1;
          end else begin
            state_nxt   = IDLE;
            hc_nxt      = '0;
            dwell_nxt   = '0;
            signal_nxt  = 1'b0;
            cur_div_nxt = MIN_D;
            busy_nxt    = 1'b0;
          end
        end
        if (stop) begin
          state_nxt       = IDLE;
          hc_nxt          = '0;
          dwell_nxt       = '0;
          signal_nxt      = 1'b0;
          cur_div_nxt     = MIN_D;
          busy_nxt        = 1'b0;
          step_strobe_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_divider_sweep_controller.sv
// Directed bench for divider_sweep_controller with MIN_DIV=1, MAX_DIV=3, DWELL_LOG2=4.
// Outputs are packed as {signal, busy, step_strobe, cur_div} and sampled 1 time unit after each rising edge.
module tb_divider_sweep_controller;

  logic       clk;
  logic       rst_n;
  logic       start, stop, hold, loop;
  logic       signal;
  logic [4:0] cur_div;
  logic       busy;
  logic       step_strobe;

  int n_checks;
  int n_fail;

  localparam logic [7:0] IDLE_VEC = {1'b0, 1'b0, 1'b0, 5'd1};

  divider_sweep_controller #(
    .MIN_DIV   (1),
    .MAX_DIV   (3),
    .DWELL_LOG2(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .hold       (hold),
    .loop       (loop),
    .signal     (signal),
    .cur_div    (cur_div),
    .busy       (busy),
    .step_strobe(step_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {signal, busy, step_strobe, cur_div};
  endfunction

  // Expected outputs k edges after start sampled (no hold): 16-cycle dwell per divisor 1,2,3.
  function automatic logic [7:0] exp_vec(input int k);
    int div;
    int j;
    div = 1 + (k / 16) % 3;
    j   = k % 16;
    return {1'(((j >> (div - 1)) & 1)), 1'b1, (k > 0 && j == 0), 5'(div)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0; stop = 1'b0; hold = 1'b0; loop = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL reset_async got %b exp %b", obs(), IDLE_VEC);
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (obs() !== IDLE_VEC) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got %b exp %b", i, obs(), IDLE_VEC);
      end
    end
  endtask

  task automatic test_single_pass();
    int strobes;
    strobes = 0;
    loop  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 48; k++) begin
      n_checks++;
      if (obs() !== exp_vec(k)) begin
        n_fail++;
        $display("FAIL single_pass k=%0d got %b exp %b", k, obs(), exp_vec(k));
      end
      if (step_strobe) strobes++;
      tick();
    end
    n_checks++;
    if (obs() !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL single_pass_end got %b exp %b", obs(), IDLE_VEC);
    end
    n_checks++;
    if (strobes != 2) begin
      n_fail++;
      $display("FAIL single_pass_strobes got %0d exp 2", strobes);
    end
  endtask

  task automatic test_loop();
    loop  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 96; k++) begin
      n_checks++;
      if (obs() !== exp_vec(k)) begin
        n_fail++;
        $display("FAIL loop k=%0d got %b exp %b", k, obs(), exp_vec(k));
      end
      if (k < 96) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop = 1'b0;
    n_checks++;
    if (obs() !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL loop_stop got %b exp %b", obs(), IDLE_VEC);
    end
  endtask

  task automatic test_hold();
    logic [7:0] e;
    loop  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) tick();
    // m = edges since cur_div became 2; hold sampled on edges m=5..14.
    for (int m = 0; m <= 26; m++) begin
      if (m < 26) e = {1'(((m >> 1) & 1)), 1'b1, (m == 0), 5'd2};
      else        e = {1'b0, 1'b1, 1'b1, 5'd3};
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL hold m=%0d got %b exp %b", m, obs(), e);
      end
      if (m == 4)  hold = 1'b1;
      if (m == 14) hold = 1'b0;
      if (m < 26) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_priority();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    n_checks++;
    if (obs() !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL prio_idle_startstop got %b exp %b", obs(), IDLE_VEC);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    n_checks++;
    if (obs() !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL prio_stop_over_start got %b exp %b", obs(), IDLE_VEC);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (obs() !== exp_vec(21)) begin
      n_fail++;
      $display("FAIL prio_start_while_busy got %b exp %b", obs(), exp_vec(21));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    n_checks++;
    if (obs() !== exp_vec(20)) begin
      n_fail++;
      $display("FAIL areset_pre got %b exp %b", obs(), exp_vec(20));
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL areset_immediate got %b exp %b", obs(), IDLE_VEC);
    end
    #2 rst_n = 1'b1;
    tick();
    n_checks++;
    if (obs() !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL areset_release got %b exp %b", obs(), IDLE_VEC);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (obs() !== exp_vec(k)) begin
        n_fail++;
        $display("FAIL areset_restart k=%0d got %b exp %b", k, obs(), exp_vec(k));
      end
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_pass();
    test_loop();
    test_hold();
    test_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_sweep_controller.md
Name: divider_sweep_controller

Overview:
- Sequences a power-of-two clock-divider test source through a range of divisors. Produces a 50%-duty square wave on `signal` for CRO bring-up.
- Starting at MIN_DIV, holds each divisor for a fixed dwell time, then steps up to MAX_DIV.
- At the end of the range it either stops or wraps to MIN_DIV, selected by `loop`.
- Sits between the board clock (50 MHz) and the test pin. Replaces a fixed-divisor divider with a hands-free frequency sweep.

Parameters:
- MIN_DIV, 1: first divisor exponent; output frequency = f_clk / 2^MIN_DIV.
- MAX_DIV, 21: last divisor exponent.
- DWELL_LOG2, 26: dwell per step = 2^DWELL_LOG2 clk cycles (about 1.34 s at 50 MHz).
- Legal range: 1 <= MIN_DIV <= MAX_DIV <= 31, and DWELL_LOG2 >= MAX_DIV. Checked by a simulation-time assertion.

Ports:
- clk  input  1  system clock (50 MHz board clock).
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin sweep; sampled on the rising edge of clk.
- stop  input  1  abort sweep, return to IDLE.
- hold  input  1  freeze dwell timer; current divisor is held.
- loop  input  1  1 = wrap MAX_DIV->MIN_DIV forever; 0 = single pass.
- signal  output  1  square-wave test output.
- cur_div  output  5  divisor exponent currently driving `signal`.
- busy  output  1  high in SWEEP or PAUSE.
- step_strobe  output  1  one-cycle pulse on each divisor change.

Behaviour:
- Clocking and reset:
  - One clock domain (`clk`). Reset is asynchronous and active-low on `rst_n`.
  - All outputs are registered.
  - Reset values: signal=0, cur_div=MIN_DIV, busy=0, step_strobe=0, state=IDLE, all counters 0.
  - Reset asserted mid-operation forces these values immediately, with no clock edge required.
- State machine:
  - States: IDLE, SWEEP, PAUSE.
  - IDLE -> SWEEP when start=1 and stop=0.
  - SWEEP -> PAUSE when hold=1. PAUSE -> SWEEP when hold=0.
  - SWEEP or PAUSE -> IDLE when stop=1. Stop has priority over start and hold in the same cycle.
  - start while busy is ignored.
- Start latency: with start sampled at edge N, the outputs after edge N are busy=1, cur_div=MIN_DIV, half-period counter=0, signal=0.
- Half-period counter (hc, 31 bits):
  - Active in SWEEP and PAUSE.
  - If hc == 2^(cur_div-1)-1: hc<=0 and signal<=~signal. Otherwise hc<=hc+1.
  - Gives period 2^cur_div cycles at exactly 50% duty. cur_div=1 toggles every cycle (f_clk/2).
- Dwell counter (DWELL_LOG2 bits):
  - Increments only in SWEEP. It is frozen in PAUSE, while `signal` keeps toggling.
- Step event: in SWEEP, dwell counter all-ones at an edge:
  - If cur_div < MAX_DIV: cur_div<=cur_div+1.
  - Else if loop=1: cur_div<=MIN_DIV.
  - Else (loop=0): go to IDLE.
  - On a divisor change: hc<=0, signal<=0, dwell<=0, step_strobe=1 for exactly that one cycle. This gives a glitch-free restart at the new frequency.
  - The end-of-pass transition to IDLE produces no step_strobe.
- MIN_DIV == MAX_DIV with loop=1: a step event reloads the same divisor. step_strobe still pulses and the phase restarts.
- IDLE: signal=0, cur_div=MIN_DIV, busy=0, counters held at 0.
- hold and stop have no effect in IDLE.
- `loop` is sampled only at the step event, so changing it mid-dwell is legal.

Test Plan:
All scenarios use MIN_DIV=1, MAX_DIV=3, DWELL_LOG2=4 (16 cycles per step).
1. Reset: drive rst_n=0 with no clock edges -> signal=0, busy=0, cur_div=1, step_strobe=0. Release reset, hold inputs low for 20 cycles -> outputs unchanged.
2. Single pass: start pulse, loop=0 -> outputs:
   - cur_div=1 for 16 cycles (period 2), then 2 for 16 (period 4), then 3 for 16 (period 8).
   - step_strobe pulses exactly twice.
   - busy falls 48 cycles after start, with signal=0 and cur_div=1.
3. Loop: loop=1, start -> after the cur_div=3 dwell, cur_div returns to 1 with a step_strobe pulse and signal=0. busy stays 1 through 2 full passes (96 cycles).
4. Hold: assert hold for 10 cycles at cycle 5 of the cur_div=2 dwell -> step to 3 occurs 26 cycles after entering div 2. signal keeps period 4 throughout PAUSE.
5. Priority: stop and start in the same cycle during SWEEP -> IDLE next cycle, busy=0, signal=0. Start asserted during SWEEP alone -> no restart, cur_div unchanged.
6. Async reset mid-sweep at cur_div=2: drop rst_n between clock edges -> outputs at reset values immediately. After release, start -> sweep restarts at cur_div=1.
